// File: rtl/inst_buffer_pkg.sv
// ---------------------------------------------------------------------------
// inst_buffer_pkg
// Shared constants for the IF -> ID instruction buffer: issue-width encoding,
// reset polarity, bus widths and the default queue depth.
// ---------------------------------------------------------------------------
package inst_buffer_pkg;

    localparam int IB_DEPTH    = 16;   // default queue depth (power of two, >= 4)
    localparam int INST_W      = 32;   // instruction word width
    localparam int INST_ADDR_W = 32;   // PC width
    localparam int CORR_PACK_W = 36;   // BPU correction packet width

    localparam logic DUAL_ISSUE   = 1'b1;
    localparam logic SINGLE_ISSUE = 1'b0;
    localparam logic RST_ENABLE   = 1'b1;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Smaller of two 2-bit entry counts.
    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage : inst_buffer_pkg

// File: rtl/ib_ram.sv
// ---------------------------------------------------------------------------
// ib_ram
// Storage array for the instruction buffer: DEPTH entries, two synchronous
// write ports and two asynchronous read ports. The two write addresses are
// always tail and tail+1, so they never collide.
// Ports:
//   clk                 clock
//   we1_i/we2_i         write enables
//   waddr1_i/waddr2_i   write addresses
//   wdata1_i/wdata2_i   write data
//   raddr1_i/raddr2_i   read addresses (head, head+1)
//   rdata1_o/rdata2_o   combinational read data
// ---------------------------------------------------------------------------
module ib_ram #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int WIDTH = 100
) (
    input  logic             clk,
    input  logic             we1_i,
    input  logic [PTR_W-1:0] waddr1_i,
    input  logic [WIDTH-1:0] wdata1_i,
    input  logic             we2_i,
    input  logic [PTR_W-1:0] waddr2_i,
    input  logic [WIDTH-1:0] wdata2_i,
    input  logic [PTR_W-1:0] raddr1_i,
    output logic [WIDTH-1:0] rdata1_o,
    input  logic [PTR_W-1:0] raddr2_i,
    output logic [WIDTH-1:0] rdata2_o
);

    // NOTE: the array has no reset; the pointers and count decide which
    // entries are meaningful, so clearing storage would only cost area.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
        if (we2_i) mem_q[waddr2_i] <= wdata2_i;
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule : ib_ram

// File: rtl/inst_buffer.sv
// ---------------------------------------------------------------------------
// inst_buffer
// Dual-entry-per-cycle circular instruction queue between fetch and a
// dual-issue decode stage. Presents the two oldest entries to ID.
// Optional feature macro: IB_BYPASS_EN -- when the queue is empty, accepted
// pushes are forwarded to the outputs in the same cycle and may be popped
// immediately; only the unpopped ones are stored.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       drop every entry (exception / mispredict)
//   push1_i/push2_i             fetch slot write requests
//   inst*_i, inst*_addr_i, corr*_i   fetch slot payloads
//   pop_i, issue_i              consume 1 (single) or 2 (dual) entries
//   inst*_o, inst*_addr_o, corr*_o   head / head+1 payloads (0 when invalid)
//   valid1_o/valid2_o           at least 1 / 2 entries presented
//   full_o                      fewer than two free slots; IF must stall
//   count_o                     occupied entries
// ---------------------------------------------------------------------------
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH  = IB_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CORR_W = CORR_PACK_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push1_i,
    input  logic                   push2_i,
    input  logic [INST_W-1:0]      inst1_i,
    input  logic [INST_W-1:0]      inst2_i,
    input  logic [INST_ADDR_W-1:0] inst1_addr_i,
    input  logic [INST_ADDR_W-1:0] inst2_addr_i,
    input  logic [CORR_W-1:0]      corr1_i,
    input  logic [CORR_W-1:0]      corr2_i,
    input  logic                   pop_i,
    input  logic                   issue_i,
    output logic [INST_W-1:0]      inst1_o,
    output logic [INST_W-1:0]      inst2_o,
    output logic [INST_ADDR_W-1:0] inst1_addr_o,
    output logic [INST_ADDR_W-1:0] inst2_addr_o,
    output logic [CORR_W-1:0]      corr1_o,
    output logic [CORR_W-1:0]      corr2_o,
    output logic                   valid1_o,
    output logic                   valid2_o,
    output logic                   full_o,
    output logic [PTR_W:0]         count_o
);

    localparam int ENTRY_W = INST_W + INST_ADDR_W + CORR_W;

    localparam logic [PTR_W:0]   CNT_ZERO = '0;
    localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic               full;
    logic               push_ok;
    logic               bypass;
    logic [1:0]         n_push, n_req, n_avail, n_pop, n_skip, n_wr;
    logic [ENTRY_W-1:0] slot1_ent, slot2_ent;
    logic [ENTRY_W-1:0] push_a, push_b;     // accepted pushes in program order
    logic [ENTRY_W-1:0] rd1_ent, rd2_ent;
    logic [ENTRY_W-1:0] out1_ent, out2_ent;
    logic               we1, we2;
    logic [ENTRY_W-1:0] wdata1;

    // -----------------------------------------------------------------------
    // Push / pop arithmetic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so
        // no branch can leave a latch behind.
        slot1_ent = {inst1_i, inst1_addr_i, corr1_i};
        slot2_ent = {inst2_i, inst2_addr_i, corr2_i};

        // full is taken from the registered count only: pop_i never reaches it.
        full    = (count_q >= CNT_FULL);
        push_ok = !full && !flush && (rst != RST_ENABLE);
        n_push  = push_ok ? ({1'b0, push1_i} + {1'b0, push2_i}) : 2'd0;

        // A lone push2 still lands first in order.
        push_a = push1_i ? slot1_ent : slot2_ent;
        push_b = slot2_ent;

        n_req = pop_i ? ((issue_i == DUAL_ISSUE) ? 2'd2 : 2'd1) : 2'd0;

`ifdef IB_BYPASS_EN
        bypass = (count_q == CNT_ZERO) && (n_push != 2'd0);
`else
        bypass = 1'b0;
`endif

        // Entries ID can take this cycle: stored ones, or the forwarded pushes.
        n_avail = bypass ? n_push : ((count_q >= CNT_TWO) ? 2'd2 : count_q[1:0]);
        n_pop   = flush ? 2'd0 : min2(n_req, n_avail);

        // Forwarded entries consumed this cycle are never written.
        n_skip = bypass ? n_pop : 2'd0;
        n_wr   = n_push - n_skip;
        we1    = (n_wr != 2'd0);
        we2    = (n_wr == 2'd2);
        wdata1 = (n_skip == 2'd0) ? push_a : push_b;

        head_d  = head_q + (bypass ? '0 : PTR_W'(n_pop));
        tail_d  = tail_q + PTR_W'(n_wr);
        count_d = count_q + (PTR_W+1)'(n_push) - (PTR_W+1)'(n_pop);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    ib_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk      (clk),
        .we1_i    (we1),
        .waddr1_i (tail_q),
        .wdata1_i (wdata1),
        .we2_i    (we2),
        .waddr2_i (tail_q + PTR_ONE),
        .wdata2_i (push_b),
        .raddr1_i (head_q),
        .rdata1_o (rd1_ent),
        .raddr2_i (head_q + PTR_ONE),
        .rdata2_o (rd2_ent)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        valid1_o = bypass ? 1'b1 : (count_q != CNT_ZERO);
        valid2_o = bypass ? (n_push == 2'd2) : (count_q >= CNT_TWO);
        out1_ent = '0;
        out2_ent = '0;
        if (valid1_o) out1_ent = bypass ? push_a : rd1_ent;
        if (valid2_o) out2_ent = bypass ? push_b : rd2_ent;
    end

    assign inst1_o      = out1_ent[ENTRY_W-1 -: INST_W];
    assign inst2_o      = out2_ent[ENTRY_W-1 -: INST_W];
    assign inst1_addr_o = out1_ent[CORR_W+INST_ADDR_W-1 -: INST_ADDR_W];
    assign inst2_addr_o = out2_ent[CORR_W+INST_ADDR_W-1 -: INST_ADDR_W];
    assign corr1_o      = out1_ent[CORR_W-1:0];
    assign corr2_o      = out2_ent[CORR_W-1:0];
    assign full_o       = full;
    assign count_o      = count_q;

endmodule : inst_buffer

// File: tb/tb_inst_buffer.sv
// ---------------------------------------------------------------------------
// tb_inst_buffer
// Self-checking bench for inst_buffer. A queue scoreboard holds the entries
// the buffer should contain; each cycle the presented head entries, flags and
// count are compared against it. A vector table drives the main sequence.
// ---------------------------------------------------------------------------
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int CW    = CORR_PACK_W;
    localparam int EW    = INST_W + INST_ADDR_W + CW;

    typedef logic [EW-1:0] ent_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        p1;
        logic        p2;
        logic        pop;
        logic        dual;
        int          reps;
        int          exp_count;   // count after the last repetition
        logic        exp_full;
        logic [31:0] exp_pc;      // non-zero: expected inst1/inst2 PCs
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst, flush, push1_i, push2_i, pop_i, issue_i;
    logic [INST_W-1:0]      inst1_i, inst2_i, inst1_o, inst2_o;
    logic [INST_ADDR_W-1:0] inst1_addr_i, inst2_addr_i, inst1_addr_o, inst2_addr_o;
    logic [CW-1:0]          corr1_i, corr2_i, corr1_o, corr2_o;
    logic                   valid1_o, valid2_o, full_o;
    logic [PTR_W:0]         count_o;

    ent_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc;
    vec_t        tbl[20];

    always #5 clk = ~clk;

    inst_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push1_i      (push1_i),
        .push2_i      (push2_i),
        .inst1_i      (inst1_i),
        .inst2_i      (inst2_i),
        .inst1_addr_i (inst1_addr_i),
        .inst2_addr_i (inst2_addr_i),
        .corr1_i      (corr1_i),
        .corr2_i      (corr2_i),
        .pop_i        (pop_i),
        .issue_i      (issue_i),
        .inst1_o      (inst1_o),
        .inst2_o      (inst2_o),
        .inst1_addr_o (inst1_addr_o),
        .inst2_addr_o (inst2_addr_o),
        .corr1_o      (corr1_o),
        .corr2_o      (corr2_o),
        .valid1_o     (valid1_o),
        .valid2_o     (valid2_o),
        .full_o       (full_o),
        .count_o      (count_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic p1, input logic p2,
                         input logic pp, input logic dual);
        rst          = r;
        flush        = f;
        push1_i      = p1;
        push2_i      = p2;
        pop_i        = pp;
        issue_i      = dual ? DUAL_ISSUE : SINGLE_ISSUE;
        inst1_i      = $urandom;
        inst2_i      = $urandom;
        inst1_addr_i = pc;
        inst2_addr_i = pc + 32'd4;
        corr1_i      = CW'({$urandom, $urandom});
        corr2_i      = CW'({$urandom, $urandom});
        pc           = pc + ((p1 && p2) ? 32'd8 : ((p1 || p2) ? 32'd4 : 32'd0));
    endtask

    // Reference queue behaviour for the cycle whose inputs are still applied.
    task automatic model_step();
        int   n_req, n_pop;
        bit   full, byp;
        ent_t e1, e2;
        if (rst || flush) begin
            sb.delete();
            return;
        end
        full  = (DEPTH - sb.size()) < 2;
        n_req = pop_i ? ((issue_i == DUAL_ISSUE) ? 2 : 1) : 0;
        e1    = {inst1_i, inst1_addr_i, corr1_i};
        e2    = {inst2_i, inst2_addr_i, corr2_i};
        byp   = 1'b0;
`ifdef IB_BYPASS_EN
        byp = (sb.size() == 0) && !full && (push1_i || push2_i);
`endif
        if (byp) begin
            // Forwarded entries are visible to ID in the same cycle.
            if (push1_i) sb.push_back(e1);
            if (push2_i) sb.push_back(e2);
            n_pop = (n_req < sb.size()) ? n_req : sb.size();
            for (int k = 0; k < n_pop; k++) void'(sb.pop_front());
        end else begin
            n_pop = (n_req < sb.size()) ? n_req : sb.size();
            for (int k = 0; k < n_pop; k++) void'(sb.pop_front());
            if (!full) begin
                if (push1_i) sb.push_back(e1);
                if (push2_i) sb.push_back(e2);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " count"},  128'(count_o),  128'(sb.size()));
        check({tag, " valid1"}, 128'(valid1_o), 128'(sb.size() >= 1));
        check({tag, " valid2"}, 128'(valid2_o), 128'(sb.size() >= 2));
        check({tag, " full"},   128'(full_o),   128'((DEPTH - sb.size()) < 2));
        if (sb.size() >= 1) check({tag, " head0"}, 128'({inst1_o, inst1_addr_o, corr1_o}), 128'(sb[0]));
        else                check({tag, " head0"}, 128'({inst1_o, inst1_addr_o, corr1_o}), 128'(0));
        if (sb.size() >= 2) check({tag, " head1"}, 128'({inst2_o, inst2_addr_o, corr2_o}), 128'(sb[1]));
        else                check({tag, " head1"}, 128'({inst2_o, inst2_addr_o, corr2_o}), 128'(0));
    endtask

    // Clock the applied inputs in, go idle, then compare against the model.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_step();
        rst = 1'b0; flush = 1'b0; push1_i = 1'b0; push2_i = 1'b0; pop_i = 1'b0;
        #1;
        compare_all(tag);
    endtask

    initial begin
        pc = 32'hBFC0_0000;
        rst = 1'b1; flush = 1'b0; push1_i = 1'b0; push2_i = 1'b0; pop_i = 1'b0;
        issue_i = SINGLE_ISSUE;
        inst1_i = '0; inst2_i = '0; inst1_addr_i = '0; inst2_addr_i = '0;
        corr1_i = '0; corr2_i = '0;

        //            rst flu p1 p2 pop dual reps cnt full pc
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2,  0, 1'b0, 32'h0};          // reset with pushes
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1,  2, 1'b0, 32'hBFC0_0000};  // first pair
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1,  0, 1'b0, 32'h0};          // dual pop
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7, 14, 1'b0, 32'h0};          // fill to 14
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 16, 1'b1, 32'h0};          // fill to 16
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 16, 1'b1, 32'h0};          // dropped
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 15, 1'b1, 32'h0};          // pop, push dropped
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5,  5, 1'b0, 32'h0};          // drain to 5
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1,  0, 1'b0, 32'h0};          // flush wins
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  1, 1'b0, 32'h0};          // one entry
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1,  0, 1'b0, 32'h0};          // over-request
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7, 14, 1'b0, 32'h0};          // advance tail
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7,  0, 1'b0, 32'h0};          // head -> 15
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1,  2, 1'b0, 32'h0};          // head 15, tail 1
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1,  3, 1'b0, 32'h0};          // wrapped read
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,  4, 1'b0, 32'h0};          // push2 alone
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1,  3, 1'b0, 32'h0};          // single pop
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2,  0, 1'b0, 32'h0};          // drain
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1,  2, 1'b0, 32'h0};          // refill
        tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1,  0, 1'b0, 32'h0};          // reset beats flush

        for (int i = 0; i < 20; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                drive(tbl[i].rst, tbl[i].flush, tbl[i].p1, tbl[i].p2, tbl[i].pop, tbl[i].dual);
                if (tbl[i].rst) pc = 32'hBFC0_0000;
                step($sformatf("row%0d.%0d", i, r));
            end
            check($sformatf("row%0d table count", i), 128'(count_o), 128'(tbl[i].exp_count));
            check($sformatf("row%0d table full", i),  128'(full_o),  128'(tbl[i].exp_full));
            if (tbl[i].exp_pc != 32'h0) begin
                check($sformatf("row%0d pc1", i), 128'(inst1_addr_o), 128'(tbl[i].exp_pc));
                check($sformatf("row%0d pc2", i), 128'(inst2_addr_o), 128'(tbl[i].exp_pc + 32'd4));
            end
        end

        // Empty queue, push pair and dual pop in the same cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
`ifdef IB_BYPASS_EN
        check("byp same-cycle valid1", 128'(valid1_o), 128'(1));
        check("byp same-cycle valid2", 128'(valid2_o), 128'(1));
        check("byp same-cycle head0", 128'({inst1_o, inst1_addr_o, corr1_o}),
              128'({inst1_i, inst1_addr_i, corr1_i}));
        check("byp same-cycle head1", 128'({inst2_o, inst2_addr_o, corr2_o}),
              128'({inst2_i, inst2_addr_i, corr2_i}));
        step("byp dual");
        check("byp dual count", 128'(count_o), 128'(0));
        // Pair pushed, one popped: only the second slot is stored.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("byp single head0", 128'({inst1_o, inst1_addr_o, corr1_o}),
              128'({inst1_i, inst1_addr_i, corr1_i}));
        step("byp single");
        check("byp single count", 128'(count_o), 128'(1));
`else
        check("nobyp same-cycle valid1", 128'(valid1_o), 128'(0));
        check("nobyp same-cycle inst1", 128'(inst1_o), 128'(ZERO_WORD));
        step("nobyp push+pop");
        check("nobyp count", 128'(count_o), 128'(2));
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("final drain");
        check("final count", 128'(count_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_buffer
